// File: rtl/exe_stage_pkg.sv
// Shared definitions for the execute stage: ALU/MD op codes, divider constants, payload struct.
package exe_stage_pkg;

  localparam int DIV_STEPS = 32;

  localparam logic [4:0] ALU_ADD  = 5'd0;
  localparam logic [4:0] ALU_SUB  = 5'd1;
  localparam logic [4:0] ALU_SLT  = 5'd2;
  localparam logic [4:0] ALU_SLTU = 5'd3;
  localparam logic [4:0] ALU_AND  = 5'd4;
  localparam logic [4:0] ALU_NOR  = 5'd5;
  localparam logic [4:0] ALU_OR   = 5'd6;
  localparam logic [4:0] ALU_XOR  = 5'd7;
  localparam logic [4:0] ALU_SLL  = 5'd8;
  localparam logic [4:0] ALU_SRL  = 5'd9;
  localparam logic [4:0] ALU_SRA  = 5'd10;
  localparam logic [4:0] ALU_LUI  = 5'd11;
  localparam logic [4:0] ALU_ADDS = 5'd12;
  localparam logic [4:0] ALU_SUBS = 5'd13;

  localparam logic [3:0] MD_NONE  = 4'd0;
  localparam logic [3:0] MD_MULT  = 4'd1;
  localparam logic [3:0] MD_MULTU = 4'd2;
  localparam logic [3:0] MD_DIV   = 4'd3;
  localparam logic [3:0] MD_DIVU  = 4'd4;
  localparam logic [3:0] MD_MFHI  = 4'd5;
  localparam logic [3:0] MD_MFLO  = 4'd6;
  localparam logic [3:0] MD_MTHI  = 4'd7;
  localparam logic [3:0] MD_MTLO  = 4'd8;

  typedef enum logic [1:0] {DIV_IDLE, DIV_BUSY, DIV_DONE} div_state_e;

  typedef struct packed {
    logic [4:0]  alu_op;
    logic [31:0] src1;
    logic [31:0] src2;
    logic [31:0] rt_value;
    logic [4:0]  dest;
    logic [3:0]  md_op;
    logic        is_load;
    logic        mem_we;
  } es_payload_t;

endpackage

// File: rtl/exe_stage_if.sv
// ID -> EX decoded-operand bus with valid/allowin handshake.
interface exe_stage_if;
  logic        ds_valid;
  logic        es_allowin;
  logic [4:0]  ds_alu_op;
  logic [31:0] ds_src1;
  logic [31:0] ds_src2;
  logic [31:0] ds_rt_value;
  logic [4:0]  ds_dest;
  logic [3:0]  ds_md_op;
  logic        ds_is_load;
  logic        ds_mem_we;

  modport master (output ds_valid, ds_alu_op, ds_src1, ds_src2, ds_rt_value, ds_dest,
                  ds_md_op, ds_is_load, ds_mem_we, input es_allowin);
  modport slave  (input ds_valid, ds_alu_op, ds_src1, ds_src2, ds_rt_value, ds_dest,
                  ds_md_op, ds_is_load, ds_mem_we, output es_allowin);
endinterface

// File: rtl/exe_stage_alu.sv
// Combinational ALU; only ops 12/13 report signed overflow.
module alu
  import exe_stage_pkg::*;
(
  input  logic [4:0]  op,
  input  logic [31:0] src1,
  input  logic [31:0] src2,
  output logic [31:0] result,
  output logic        overflow
);
  logic [31:0] sum, diff;
  assign sum  = src1 + src2;
  assign diff = src1 - src2;

  always_comb begin
    result   = '0;
    overflow = 1'b0;
    case (op)
      ALU_ADD, ALU_ADDS: result = sum;
      ALU_SUB, ALU_SUBS: result = diff;
      ALU_SLT:  result = {31'b0, $signed(src1) < $signed(src2)};
      ALU_SLTU: result = {31'b0, src1 < src2};
      ALU_AND:  result = src1 & src2;
      ALU_NOR:  result = ~(src1 | src2);
      ALU_OR:   result = src1 | src2;
      ALU_XOR:  result = src1 ^ src2;
      ALU_SLL:  result = src2 << src1[4:0];
      ALU_SRL:  result = src2 >> src1[4:0];
      ALU_SRA:  result = $unsigned($signed(src2) >>> src1[4:0]);
      ALU_LUI:  result = {src2[15:0], 16'b0};
      default:  result = '0;
    endcase
    // overflow iff operand signs allow it and the result sign flips
    if (op == ALU_ADDS) overflow = (src1[31] == src2[31]) && (sum[31]  != src1[31]);
    if (op == ALU_SUBS) overflow = (src1[31] != src2[31]) && (diff[31] != src1[31]);
  end
endmodule

// File: rtl/exe_stage_div.sv
// Iterative restoring divider on magnitudes, one quotient bit per BUSY cycle, sign fix-up on output.
module div_iter
  import exe_stage_pkg::*;
#(
  parameter int DIV_STEPS = exe_stage_pkg::DIV_STEPS
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        kill,
  input  logic        start,
  input  logic        sgn,
  input  logic        ack,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        busy,
  output logic        done,
  output logic [31:0] quot,
  output logic [31:0] rem
);
  localparam int CW = $clog2(DIV_STEPS);

  div_state_e    state;
  logic [CW-1:0] cnt;
  logic [31:0]   q, r, dvs;
  logic          neg_q, neg_r;
  logic [32:0]   rq;
  logic          ge;

  // Divisor 0 makes every trial succeed: quotient all ones, remainder = dividend magnitude.
  assign rq = {r, q[31]};
  assign ge = rq >= {1'b0, dvs};

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= DIV_IDLE;
      cnt   <= '0;
      q     <= '0;
      r     <= '0;
      dvs   <= '0;
      neg_q <= 1'b0;
      neg_r <= 1'b0;
    end else if (kill) begin
      state <= DIV_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        DIV_IDLE: if (start) begin
          q     <= (sgn & a[31]) ? -a : a;
          dvs   <= (sgn & b[31]) ? -b : b;
          r     <= '0;
          neg_q <= sgn & (a[31] ^ b[31]);
          neg_r <= sgn & a[31];
          cnt   <= '0;
          state <= DIV_BUSY;
        end
        DIV_BUSY: begin
          r   <= ge ? 32'(rq - {1'b0, dvs}) : rq[31:0];
          q   <= {q[30:0], ge};
          cnt <= cnt + 1'b1;
          if (cnt == CW'(DIV_STEPS - 1)) state <= DIV_DONE;
        end
        DIV_DONE: if (ack) state <= DIV_IDLE;
        default:  state <= DIV_IDLE;
      endcase
    end
  end

  assign busy = (state == DIV_BUSY);
  assign done = (state == DIV_DONE);
  assign quot = neg_q ? -q : q;
  assign rem  = neg_r ? -r : r;
endmodule

// File: rtl/exe_stage.sv
// MIPS execute stage: operand register, ALU, HI/LO with mult and iterative div, MEM handoff, ID bypass.
module exe_stage
  import exe_stage_pkg::*;
#(
  parameter int DIV_STEPS = exe_stage_pkg::DIV_STEPS
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  exe_stage_if.slave       ds,
  input  logic             ms_allowin,
  output logic             es_to_ms_valid,
  output logic [31:0]      es_result,
  output logic [31:0]      es_rt_value,
  output logic [4:0]       es_dest,
  output logic             es_is_load,
  output logic             es_mem_we,
  output logic             es_exc_ov,
  output logic [4:0]       es_fwd_dest,
  output logic             es_fwd_load
);
  es_payload_t pl;
  logic        es_valid, es_ready_go, fire, is_div, div_busy, div_done, alu_ov, mul_sgn;
  logic [31:0] alu_res, quot, rem, hi, lo;
  logic [63:0] ext1, ext2, prod;

  assign is_div         = (pl.md_op == MD_DIV) || (pl.md_op == MD_DIVU);
  assign es_ready_go    = ~is_div | div_done;
  assign ds.es_allowin  = ~es_valid | (es_ready_go & ms_allowin);
  assign es_to_ms_valid = es_valid & es_ready_go & ~flush;
  assign fire           = es_to_ms_valid & ms_allowin;

  always_ff @(posedge clk) begin
    if (reset) begin
      es_valid <= 1'b0;
      pl       <= '0;
    end else begin
      if (flush)              es_valid <= 1'b0;
      else if (ds.es_allowin) es_valid <= ds.ds_valid;
      if (ds.es_allowin & ds.ds_valid & ~flush)
        pl <= '{alu_op: ds.ds_alu_op, src1: ds.ds_src1, src2: ds.ds_src2,
                rt_value: ds.ds_rt_value, dest: ds.ds_dest, md_op: ds.ds_md_op,
                is_load: ds.ds_is_load, mem_we: ds.ds_mem_we};
    end
  end

  alu u_alu (
    .op(pl.alu_op), .src1(pl.src1), .src2(pl.src2), .result(alu_res), .overflow(alu_ov)
  );

  div_iter #(.DIV_STEPS(DIV_STEPS)) u_div (
    .clk, .reset, .kill(flush),
    .start(es_valid & is_div & ~div_busy & ~div_done),
    .sgn(pl.md_op == MD_DIV), .ack(fire), .a(pl.src1), .b(pl.src2),
    .busy(div_busy), .done(div_done), .quot, .rem
  );

  // Sign/zero-extend to 64 bits so one unsigned multiply serves mult and multu.
  assign mul_sgn = (pl.md_op == MD_MULT);
  assign ext1    = {{32{mul_sgn & pl.src1[31]}}, pl.src1};
  assign ext2    = {{32{mul_sgn & pl.src2[31]}}, pl.src2};
  assign prod    = ext1 * ext2;

  // Committing only on fire keeps a stalled instruction to a single HI/LO write.
  always_ff @(posedge clk) begin
    if (reset) begin
      hi <= '0;
      lo <= '0;
    end else if (fire & ~alu_ov) begin
      case (pl.md_op)
        MD_MULT, MD_MULTU: {hi, lo} <= prod;
        MD_DIV, MD_DIVU: begin
          lo <= quot;
          hi <= rem;
        end
        MD_MTHI: hi <= pl.src1;
        MD_MTLO: lo <= pl.src1;
        default: ;
      endcase
    end
  end

  assign es_result   = (pl.md_op == MD_MFHI) ? hi :
                       (pl.md_op == MD_MFLO) ? lo : alu_res;
  assign es_rt_value = pl.rt_value;
  assign es_dest     = alu_ov ? 5'd0 : pl.dest;
  assign es_is_load  = pl.is_load;
  assign es_mem_we   = pl.mem_we & ~alu_ov;
  assign es_exc_ov   = alu_ov;
  assign es_fwd_dest = es_valid ? es_dest : 5'd0;
  assign es_fwd_load = es_valid & pl.is_load;
endmodule
